// File: rtl/msrv32_fetch_sequencer_if.sv
// Instruction-memory handshake bundle for the fetch sequencer.
// The master side (fetch sequencer) drives the request and address; the
// slave side (instruction memory) returns the one-cycle completion strobe.
interface msrv32_fetch_sequencer_if;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_ack_in;

  modport master (
    output imem_req_out,
    output imem_addr_out,
    input  imem_ack_in
  );

  modport slave (
    input  imem_req_out,
    input  imem_addr_out,
    output imem_ack_in
  );
endinterface

// File: rtl/msrv32_fetch_sequencer.sv
// Fetch sequencer: owns the fetch PC, keeps at most one instruction-memory
// request in flight, selects the next PC (trap > branch > +4) and hands the
// fetched PC to decode through a valid/stall handshake. A request that is
// redirected before its ack is left up until the ack arrives (DROP) so that
// the memory never sees an address change under an outstanding request.
module msrv32_fetch_sequencer #(
  parameter logic [31:0] BOOT_ADDR   = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                            ms_riscv32_mp_clk_in,
  input  logic                            ms_riscv32_mp_rst_in,
  msrv32_fetch_sequencer_if.master        imem,
  input  logic                            branch_taken_in,
  input  logic [31:0]                     branch_target_in,
  input  logic                            trap_taken_in,
  input  logic [31:0]                     trap_vector_in,
  input  logic                            stall_in,
  output logic [31:0]                     pc_out,
  output logic [31:0]                     pc_plus_4_out,
  output logic                            pc_valid_out,
  output logic                            misaligned_out,
  output logic                            fetch_err_out
);

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DROP  = 2'd2,
    ST_VALID = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        pend_pc_q, pend_pc_d;
  logic [31:0]        pc_q, pc_d;
  logic               req_q, req_d;
  logic               valid_q, valid_d;
  logic               misaligned_q;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               redirect_s;
  logic               misaligned_s;
  logic [31:0]        target_s;
  logic [31:0]        trap_target_s;
  logic               req_active_s;

  // Trap vectors are word aligned by construction: low two bits forced to zero.
  assign trap_target_s = trap_vector_in & 32'hFFFF_FFFC;

  // Redirect arbitration: trap wins; a branch only redirects to an aligned target.
  always_comb begin
    redirect_s   = 1'b0;
    misaligned_s = 1'b0;
    target_s     = 32'h0000_0000;
    if (trap_taken_in) begin
      redirect_s = 1'b1;
      target_s   = trap_target_s;
    end else if (branch_taken_in) begin
      if (branch_target_in[1:0] == 2'b00) begin
        redirect_s = 1'b1;
        target_s   = branch_target_in;
      end else begin
        misaligned_s = 1'b1;
      end
    end else begin
      redirect_s = 1'b0;
    end
  end

  // Next-state, next-PC and registered-output decode for the fetch FSM.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    pc_d       = pc_q;
    case (state_q)
      ST_BOOT: begin
        if (redirect_s) begin
          fetch_pc_d = target_s;
        end else begin
          fetch_pc_d = fetch_pc_q;
        end
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (imem.imem_ack_in) begin
          if (redirect_s) begin
            // Returned instruction belongs to the old path: drop it, re-request.
            fetch_pc_d = target_s;
          end else begin
            pc_d       = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = ST_VALID;
          end
        end else if (redirect_s) begin
          pend_pc_d = target_s;
          state_d   = ST_DROP;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_DROP: begin
        if (imem.imem_ack_in) begin
          if (redirect_s) begin
            fetch_pc_d = target_s;
          end else begin
            fetch_pc_d = pend_pc_q;
          end
          state_d = ST_REQ;
        end else if (redirect_s) begin
          pend_pc_d = target_s;
        end else begin
          state_d = ST_DROP;
        end
      end
      ST_VALID: begin
        if (redirect_s) begin
          fetch_pc_d = target_s;
          state_d    = ST_REQ;
        end else if (!stall_in) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_VALID;
        end
      end
      default: begin
        state_d    = ST_BOOT;
        fetch_pc_d = BOOT_ADDR;
      end
    endcase
    req_d   = (state_d == ST_REQ) || (state_d == ST_DROP);
    valid_d = (state_d == ST_VALID);
  end

  assign req_active_s = (state_q == ST_REQ) || (state_q == ST_DROP);

  // Ack watchdog: count unanswered request cycles, pulse an error and retry.
  always_comb begin
    cnt_d = {CNT_W{1'b0}};
    err_d = 1'b0;
    if (req_active_s && !imem.imem_ack_in) begin
      if ((cnt_q + CNT_W'(1)) == CNT_W'(ACK_TIMEOUT)) begin
        cnt_d = {CNT_W{1'b0}};
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        err_d = 1'b0;
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
      err_d = 1'b0;
    end
  end

  // State and datapath registers, cleared immediately by the async reset.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state_q      <= ST_BOOT;
      fetch_pc_q   <= BOOT_ADDR;
      pend_pc_q    <= BOOT_ADDR;
      pc_q         <= BOOT_ADDR;
      req_q        <= 1'b0;
      valid_q      <= 1'b0;
      misaligned_q <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pend_pc_q    <= pend_pc_d;
      pc_q         <= pc_d;
      req_q        <= req_d;
      valid_q      <= valid_d;
      misaligned_q <= misaligned_s;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign imem.imem_req_out  = req_q;
  assign imem.imem_addr_out = fetch_pc_q;
  assign pc_out             = pc_q;
  assign pc_plus_4_out      = pc_q + 32'd4;
  assign pc_valid_out       = valid_q;
  assign misaligned_out     = misaligned_q;
  assign fetch_err_out      = err_q;

endmodule

// File: tb/tb_msrv32_fetch_sequencer.sv
// Directed bench for the fetch sequencer. Inputs are driven and outputs are
// observed on the falling clock edge; the DUT acts on the rising edge.
// A second instance booting at 32'hFFFF_FFFC covers PC wrap-around.
module tb_msrv32_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        trap_taken;
  logic [31:0] trap_vector;
  logic        stall;
  logic [31:0] pc, pc4, pc_w, pc4_w;
  logic        valid, mis, err, valid_w, mis_w, err_w;
  int          checks   = 0;
  int          failures = 0;

  msrv32_fetch_sequencer_if if_m ();
  msrv32_fetch_sequencer_if if_w ();

  always #5 clk = ~clk;

  msrv32_fetch_sequencer #(.BOOT_ADDR(32'h0000_0000), .ACK_TIMEOUT(16)) dut (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst_n), .imem(if_m),
    .branch_taken_in(branch_taken), .branch_target_in(branch_target),
    .trap_taken_in(trap_taken), .trap_vector_in(trap_vector), .stall_in(stall),
    .pc_out(pc), .pc_plus_4_out(pc4), .pc_valid_out(valid),
    .misaligned_out(mis), .fetch_err_out(err));

  msrv32_fetch_sequencer #(.BOOT_ADDR(32'hFFFF_FFFC), .ACK_TIMEOUT(4)) dut_w (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst_n), .imem(if_w),
    .branch_taken_in(branch_taken), .branch_target_in(branch_target),
    .trap_taken_in(trap_taken), .trap_vector_in(trap_vector), .stall_in(stall),
    .pc_out(pc_w), .pc_plus_4_out(pc4_w), .pc_valid_out(valid_w),
    .misaligned_out(mis_w), .fetch_err_out(err_w));

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; branch_taken = 1'b0; branch_target = 32'h0; trap_taken = 1'b0;
    trap_vector = 32'h0; stall = 1'b0; if_m.imem_ack_in = 1'b0; if_w.imem_ack_in = 1'b0;
    step(); step();
    checks++; if (if_m.imem_req_out !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", if_m.imem_req_out); end
    checks++; if (if_m.imem_addr_out !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=00000000", if_m.imem_addr_out); end
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=00000000", pc); end
    checks++; if ({valid, mis, err} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {valid, mis, err}); end
    checks++; if (if_w.imem_addr_out !== 32'hFFFF_FFFC) begin failures++; $display("FAIL rst_addr_w got=%h exp=fffffffc", if_w.imem_addr_out); end
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    step();
    for (int k = 0; k < 4; k++) begin
      checks++; if (if_m.imem_req_out !== 1'b1 || if_m.imem_addr_out !== 32'(4 * k))
        begin failures++; $display("FAIL seq_req k=%0d got=%b/%h exp=1/%h", k, if_m.imem_req_out, if_m.imem_addr_out, 32'(4 * k)); end
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL seq_novalid k=%0d got=%b exp=0", k, valid); end
      if_m.imem_ack_in = 1'b1;
      step();
      if_m.imem_ack_in = 1'b0;
      checks++; if (valid !== 1'b1 || pc !== 32'(4 * k) || pc4 !== 32'(4 * k + 4))
        begin failures++; $display("FAIL seq_valid k=%0d got=%b/%h/%h exp=1/%h/%h", k, valid, pc, pc4, 32'(4 * k), 32'(4 * k + 4)); end
      checks++; if (if_m.imem_req_out !== 1'b0) begin failures++; $display("FAIL seq_req_low k=%0d got=%b exp=0", k, if_m.imem_req_out); end
      step();
    end
  endtask

  task automatic test_branch_drop();
    branch_taken = 1'b1; branch_target = 32'h0000_0100;
    step();
    branch_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (if_m.imem_req_out !== 1'b1 || if_m.imem_addr_out !== 32'h10)
        begin failures++; $display("FAIL drop_hold i=%0d got=%b/%h exp=1/00000010", i, if_m.imem_req_out, if_m.imem_addr_out); end
      if (i == 2) if_m.imem_ack_in = 1'b1;
      step();
    end
    if_m.imem_ack_in = 1'b0;
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL drop_discard got=%b exp=0", valid); end
    checks++; if (if_m.imem_req_out !== 1'b1 || if_m.imem_addr_out !== 32'h100)
      begin failures++; $display("FAIL drop_newaddr got=%b/%h exp=1/00000100", if_m.imem_req_out, if_m.imem_addr_out); end
  endtask

  task automatic test_trap_priority();
    if_m.imem_ack_in = 1'b1;
    step();
    if_m.imem_ack_in = 1'b0;
    checks++; if (valid !== 1'b1 || pc !== 32'h100) begin failures++; $display("FAIL trap_pre got=%b/%h exp=1/00000100", valid, pc); end
    trap_taken = 1'b1; trap_vector = 32'h0000_0203;
    branch_taken = 1'b1; branch_target = 32'h0000_0400;
    step();
    trap_taken = 1'b0; branch_taken = 1'b0;
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL trap_valid_drop got=%b exp=0", valid); end
    checks++; if (if_m.imem_req_out !== 1'b1 || if_m.imem_addr_out !== 32'h200)
      begin failures++; $display("FAIL trap_addr got=%b/%h exp=1/00000200", if_m.imem_req_out, if_m.imem_addr_out); end
  endtask

  task automatic test_misaligned();
    branch_taken = 1'b1; branch_target = 32'h0000_0102;
    step();
    branch_taken = 1'b0;
    checks++; if (mis !== 1'b1) begin failures++; $display("FAIL mis_pulse got=%b exp=1", mis); end
    checks++; if (if_m.imem_req_out !== 1'b1 || if_m.imem_addr_out !== 32'h200)
      begin failures++; $display("FAIL mis_addr got=%b/%h exp=1/00000200", if_m.imem_req_out, if_m.imem_addr_out); end
    step();
    checks++; if (mis !== 1'b0) begin failures++; $display("FAIL mis_end got=%b exp=0", mis); end
    if_m.imem_ack_in = 1'b1;
    step();
    if_m.imem_ack_in = 1'b0;
    checks++; if (valid !== 1'b1 || pc !== 32'h200) begin failures++; $display("FAIL mis_fetch got=%b/%h exp=1/00000200", valid, pc); end
    step();
    checks++; if (if_m.imem_req_out !== 1'b1 || if_m.imem_addr_out !== 32'h204)
      begin failures++; $display("FAIL mis_next got=%b/%h exp=1/00000204", if_m.imem_req_out, if_m.imem_addr_out); end
  endtask

  task automatic test_timeout_stall();
    for (int i = 1; i <= 32; i++) begin
      step();
      checks++; if (err !== ((i == 16) || (i == 32)))
        begin failures++; $display("FAIL tmo_err cyc=%0d got=%b exp=%b", i, err, (i == 16) || (i == 32)); end
      checks++; if (if_m.imem_req_out !== 1'b1 || if_m.imem_addr_out !== 32'h204)
        begin failures++; $display("FAIL tmo_hold cyc=%0d got=%b/%h exp=1/00000204", i, if_m.imem_req_out, if_m.imem_addr_out); end
    end
    if_m.imem_ack_in = 1'b1;
    step();
    if_m.imem_ack_in = 1'b0;
    checks++; if (valid !== 1'b1 || pc !== 32'h204 || err !== 1'b0)
      begin failures++; $display("FAIL tmo_deliver got=%b/%h/%b exp=1/00000204/0", valid, pc, err); end
    stall = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      step();
      checks++; if (valid !== 1'b1 || pc !== 32'h204 || if_m.imem_req_out !== 1'b0)
        begin failures++; $display("FAIL stall_hold j=%0d got=%b/%h/%b exp=1/00000204/0", j, valid, pc, if_m.imem_req_out); end
    end
    stall = 1'b0;
    step();
    checks++; if (valid !== 1'b0 || if_m.imem_req_out !== 1'b1 || if_m.imem_addr_out !== 32'h208)
      begin failures++; $display("FAIL stall_release got=%b/%b/%h exp=0/1/00000208", valid, if_m.imem_req_out, if_m.imem_addr_out); end
  endtask

  task automatic test_reset_mid_drop();
    branch_taken = 1'b1; branch_target = 32'h0000_0300;
    step();
    branch_taken = 1'b0;
    checks++; if (if_m.imem_req_out !== 1'b1 || if_m.imem_addr_out !== 32'h208)
      begin failures++; $display("FAIL mid_drop got=%b/%h exp=1/00000208", if_m.imem_req_out, if_m.imem_addr_out); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (if_m.imem_req_out !== 1'b0 || if_m.imem_addr_out !== 32'h0 || valid !== 1'b0)
      begin failures++; $display("FAIL async_rst got=%b/%h/%b exp=0/00000000/0", if_m.imem_req_out, if_m.imem_addr_out, valid); end
    checks++; if (if_w.imem_req_out !== 1'b0 || if_w.imem_addr_out !== 32'hFFFF_FFFC)
      begin failures++; $display("FAIL async_rst_w got=%b/%h exp=0/fffffffc", if_w.imem_req_out, if_w.imem_addr_out); end
    step(); step();
    rst_n = 1'b1;
    step();
    checks++; if (if_m.imem_req_out !== 1'b1 || if_m.imem_addr_out !== 32'h0)
      begin failures++; $display("FAIL restart got=%b/%h exp=1/00000000", if_m.imem_req_out, if_m.imem_addr_out); end
    checks++; if (if_w.imem_req_out !== 1'b1 || if_w.imem_addr_out !== 32'hFFFF_FFFC)
      begin failures++; $display("FAIL restart_w got=%b/%h exp=1/fffffffc", if_w.imem_req_out, if_w.imem_addr_out); end
    if_m.imem_ack_in = 1'b1; if_w.imem_ack_in = 1'b1;
    step();
    if_m.imem_ack_in = 1'b0; if_w.imem_ack_in = 1'b0;
    checks++; if (valid !== 1'b1 || pc !== 32'h0 || pc4 !== 32'h4)
      begin failures++; $display("FAIL restart_valid got=%b/%h/%h exp=1/00000000/00000004", valid, pc, pc4); end
    checks++; if (valid_w !== 1'b1 || pc_w !== 32'hFFFF_FFFC || pc4_w !== 32'h0)
      begin failures++; $display("FAIL wrap_valid got=%b/%h/%h exp=1/fffffffc/00000000", valid_w, pc_w, pc4_w); end
    step();
    checks++; if (if_m.imem_req_out !== 1'b1 || if_m.imem_addr_out !== 32'h4)
      begin failures++; $display("FAIL restart_next got=%b/%h exp=1/00000004", if_m.imem_req_out, if_m.imem_addr_out); end
    checks++; if (if_w.imem_req_out !== 1'b1 || if_w.imem_addr_out !== 32'h0 || err_w !== 1'b0)
      begin failures++; $display("FAIL wrap_next got=%b/%h/%b exp=1/00000000/0", if_w.imem_req_out, if_w.imem_addr_out, err_w); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch_drop();
    test_trap_priority();
    test_misaligned();
    test_timeout_stall();
    test_reset_mid_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
